// File: rtl/mel_filter_pkg.sv
// Shared constants for the log-mel filterbank weight generator.
// MEL_EDGE / MEL_RECIP are script-generated tables for 64 filters over bins 0..512.
package mel_filter_pkg;

    localparam int NUM_FILT  = 64;
    localparam int NUM_BINS  = 513;
    localparam int NUM_EDGES = NUM_FILT + 2;

    localparam int EDGE_BW  = 10;
    localparam int RECIP_BW = 14;
    localparam int W_BW     = 14;
    localparam int PROD_BW  = EDGE_BW + RECIP_BW;

    localparam int Q13_ONE = 8192;
    localparam int Q13_MAX = 8191;

    typedef logic [EDGE_BW-1:0]  bin_t;
    typedef logic [RECIP_BW-1:0] recip_t;
    typedef logic [W_BW-1:0]     weight_t;

    // floor(1024 * hz(m) / 16000), 66 points equally spaced in mel from 0 Hz to 8000 Hz
    localparam bin_t MEL_EDGE [NUM_EDGES] = '{
        10'd0,   10'd1,   10'd3,   10'd5,   10'd7,   10'd9,   10'd11,  10'd13,
        10'd16,  10'd18,  10'd21,  10'd23,  10'd26,  10'd29,  10'd32,  10'd35,
        10'd38,  10'd41,  10'd45,  10'd48,  10'd52,  10'd56,  10'd60,  10'd64,
        10'd68,  10'd73,  10'd77,  10'd82,  10'd87,  10'd93,  10'd98,  10'd104,
        10'd110, 10'd116, 10'd122, 10'd129, 10'd136, 10'd143, 10'd150, 10'd158,
        10'd166, 10'd174, 10'd183, 10'd192, 10'd201, 10'd211, 10'd221, 10'd232,
        10'd243, 10'd254, 10'd266, 10'd278, 10'd291, 10'd304, 10'd318, 10'd333,
        10'd347, 10'd363, 10'd379, 10'd396, 10'd413, 10'd432, 10'd450, 10'd470,
        10'd490, 10'd512
    };

    // round(8192 / (MEL_EDGE[m+1] - MEL_EDGE[m]))
    localparam recip_t MEL_RECIP [NUM_EDGES-1] = '{
        14'd8192, 14'd4096, 14'd4096, 14'd4096, 14'd4096, 14'd4096, 14'd4096, 14'd2731,
        14'd4096, 14'd2731, 14'd4096, 14'd2731, 14'd2731, 14'd2731, 14'd2731, 14'd2731,
        14'd2731, 14'd2048, 14'd2731, 14'd2048, 14'd2048, 14'd2048, 14'd2048, 14'd2048,
        14'd1638, 14'd2048, 14'd1638, 14'd1638, 14'd1365, 14'd1638, 14'd1365, 14'd1365,
        14'd1365, 14'd1365, 14'd1170, 14'd1170, 14'd1170, 14'd1170, 14'd1024, 14'd1024,
        14'd1024, 14'd910,  14'd910,  14'd910,  14'd819,  14'd819,  14'd745,  14'd745,
        14'd745,  14'd683,  14'd683,  14'd630,  14'd630,  14'd585,  14'd546,  14'd585,
        14'd512,  14'd512,  14'd482,  14'd482,  14'd431,  14'd455,  14'd410,  14'd410,
        14'd372
    };

    // Q1.13 cannot hold 1.0, so anything at or above it pins to the largest code.
    function automatic weight_t sat_q13(input logic [PROD_BW-1:0] p);
        return (p >= PROD_BW'(Q13_ONE)) ? weight_t'(Q13_MAX) : p[W_BW-1:0];
    endfunction

endpackage

// File: rtl/mel_filter_coef_gen_tri.sv
// One triangular mel filter: combinational Q1.13 weight of bin k given edges L < C < U.
module mel_tri_weight
    import mel_filter_pkg::*;
(
    input  logic [EDGE_BW-1:0]  i_k,
    input  logic [EDGE_BW-1:0]  i_l,
    input  logic [EDGE_BW-1:0]  i_c,
    input  logic [EDGE_BW-1:0]  i_u,
    input  logic [RECIP_BW-1:0] i_rise_recip,
    input  logic [RECIP_BW-1:0] i_fall_recip,
    output logic [W_BW-1:0]     o_w
);

    logic [EDGE_BW-1:0]  w_dist;
    logic [RECIP_BW-1:0] w_recip;
    logic [PROD_BW-1:0]  w_prod;

    // Rising slope includes the peak bin; falling slope excludes both C and U.
    always_comb begin
        w_dist  = '0;
        w_recip = '0;
        if ((i_k > i_l) && (i_k <= i_c)) begin
            w_dist  = i_k - i_l;
            w_recip = i_rise_recip;
        end else if ((i_k > i_c) && (i_k < i_u)) begin
            w_dist  = i_u - i_k;
            w_recip = i_fall_recip;
        end
        w_prod = PROD_BW'(w_dist) * PROD_BW'(w_recip);
        o_w    = sat_q13(w_prod);
    end

endmodule

// File: rtl/mel_filter_coef_gen.sv
// Per-bin mel filterbank weight generator: 64 Q1.13 weights plus the sample,
// bin index and frame flags, all registered once.
module mel_filter_coef_gen
    import mel_filter_pkg::*;
#(
    parameter int I_BW     = 14,
    parameter int O_BW     = 14,
    parameter int COEF_BW  = 14,
    parameter int NUM_FILT = 64
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [9:0]                 filter_v,
    input  logic signed [I_BW-1:0]     data_i,
    input  logic                       di_en,
    input  logic                       is_first_in,
    input  logic                       is_last_in,
    output logic [O_BW*NUM_FILT-1:0]   coef,
    output logic                       do_en,
    output logic [9:0]                 out_filter_v,
    output logic signed [O_BW-1:0]     data_o,
    output logic                       is_first_out,
    output logic                       is_last_out
);

    logic                     w_in_range;
    logic [O_BW*NUM_FILT-1:0] w_coef;
    logic signed [O_BW-1:0]   w_data;

    logic [O_BW*NUM_FILT-1:0] r_coef;
    logic                     r_do_en;
    logic [9:0]               r_filter_v;
    logic signed [O_BW-1:0]   r_data;
    logic                     r_first;
    logic                     r_last;

    // Indices past the Nyquist bin carry data only; their weights are forced to zero.
    assign w_in_range = (filter_v <= 10'(NUM_BINS - 1));
    assign w_data     = O_BW'(data_i);

    genvar gi;
    generate
        for (gi = 0; gi < NUM_FILT; gi++) begin : g_filt
            logic [W_BW-1:0]    w_tri;
            logic [COEF_BW-1:0] w_w;

            mel_tri_weight u_tri (
                .i_k          (filter_v),
                .i_l          (MEL_EDGE[gi]),
                .i_c          (MEL_EDGE[gi+1]),
                .i_u          (MEL_EDGE[gi+2]),
                .i_rise_recip (MEL_RECIP[gi]),
                .i_fall_recip (MEL_RECIP[gi+1]),
                .o_w          (w_tri)
            );

            assign w_w = COEF_BW'(w_tri);
            // Filter 0 lands in the most significant slice.
            assign w_coef[(NUM_FILT-1-gi)*O_BW +: O_BW] = w_in_range ? O_BW'(w_w) : '0;
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_coef     <= '0;
            r_do_en    <= 1'b0;
            r_filter_v <= '0;
            r_data     <= '0;
            r_first    <= 1'b0;
            r_last     <= 1'b0;
        end else begin
            r_do_en <= di_en;
            if (di_en) begin
                r_coef     <= w_coef;
                r_filter_v <= filter_v;
                r_data     <= w_data;
                r_first    <= is_first_in;
                r_last     <= is_last_in;
            end
        end
    end

    assign coef         = r_coef;
    assign do_en        = r_do_en;
    assign out_filter_v = r_filter_v;
    assign data_o       = r_data;
    assign is_first_out = r_first;
    assign is_last_out  = r_last;

endmodule

// File: tb/tb_mel_filter_coef_gen.sv
// Randomized bench for mel_filter_coef_gen against a floating-point mel filterbank model.
module tb_mel_filter_coef_gen;

    localparam int I_BW = 14;
    localparam int O_BW = 14;
    localparam int NF   = 64;
    localparam int CW   = O_BW * NF;

    logic                   clk;
    logic                   rst;
    logic [9:0]             filter_v;
    logic signed [I_BW-1:0] data_i;
    logic                   di_en;
    logic                   is_first_in;
    logic                   is_last_in;
    logic [CW-1:0]          coef;
    logic                   do_en;
    logic [9:0]             out_filter_v;
    logic signed [O_BW-1:0] data_o;
    logic                   is_first_out;
    logic                   is_last_out;

    int total;
    int bad;
    int n_txn;
    int mel_edge [66];
    int mel_recip [65];

    logic          e_do_en;
    logic [9:0]    e_fv;
    logic [O_BW-1:0] e_data;
    logic          e_first;
    logic          e_last;
    logic [CW-1:0] e_coef;

    mel_filter_coef_gen #(
        .I_BW(I_BW), .O_BW(O_BW), .COEF_BW(O_BW), .NUM_FILT(NF)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .filter_v     (filter_v),
        .data_i       (data_i),
        .di_en        (di_en),
        .is_first_in  (is_first_in),
        .is_last_in   (is_last_in),
        .coef         (coef),
        .do_en        (do_en),
        .out_filter_v (out_filter_v),
        .data_o       (data_o),
        .is_first_out (is_first_out),
        .is_last_out  (is_last_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [CW-1:0] got, input logic [CW-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Mel scale: mel(f) = 2595*log10(1+f/700); edges are bin indices of 66 equally spaced mel points.
    task automatic build_tables();
        real mel_max;
        real mel;
        real hz;
        mel_max = 2595.0 * $log10(1.0 + 8000.0 / 700.0);
        for (int m = 0; m < 66; m++) begin
            mel = mel_max * real'(m) / 65.0;
            hz  = 700.0 * ($pow(10.0, mel / 2595.0) - 1.0);
            mel_edge[m] = int'($floor(1024.0 * hz / 16000.0));
        end
        mel_edge[0]  = 0;
        mel_edge[65] = 512;
        for (int m = 0; m < 65; m++)
            mel_recip[m] = int'($floor(8192.0 / real'(mel_edge[m+1] - mel_edge[m]) + 0.5));
    endtask

    function automatic int model_w(input int j, input int k);
        int lo, ce, up, w;
        if (k > 512) return 0;
        lo = mel_edge[j];
        ce = mel_edge[j+1];
        up = mel_edge[j+2];
        if (k > lo && k <= ce)     w = (k - lo) * mel_recip[j];
        else if (k > ce && k < up) w = (up - k) * mel_recip[j+1];
        else                       w = 0;
        return (w > 8191) ? 8191 : w;
    endfunction

    function automatic logic [CW-1:0] model_coef(input int k);
        logic [CW-1:0] v;
        v = '0;
        for (int j = 0; j < NF; j++)
            v[(NF-1-j)*O_BW +: O_BW] = O_BW'(model_w(j, k));
        return v;
    endfunction

    task automatic check_all(input string tag);
        chk({tag, ".do_en"}, CW'(do_en),          CW'(e_do_en));
        chk({tag, ".fv"},    CW'(out_filter_v),   CW'(e_fv));
        chk({tag, ".data"},  CW'($unsigned(data_o)), CW'(e_data));
        chk({tag, ".first"}, CW'(is_first_out),   CW'(e_first));
        chk({tag, ".last"},  CW'(is_last_out),    CW'(e_last));
        chk({tag, ".coef"},  coef,                e_coef);
    endtask

    task automatic model_reset();
        e_do_en = 1'b0;
        e_fv    = '0;
        e_data  = '0;
        e_first = 1'b0;
        e_last  = 1'b0;
        e_coef  = '0;
    endtask

    task automatic step(input string tag, input int k, input int d, input bit en,
                        input bit f, input bit l);
        filter_v    = 10'(k);
        data_i      = I_BW'(d);
        di_en       = en;
        is_first_in = f;
        is_last_in  = l;
        @(posedge clk);
        e_do_en = en;
        if (en) begin
            e_fv    = 10'(k);
            e_data  = O_BW'(d);
            e_first = f;
            e_last  = l;
            e_coef  = model_coef(k);
        end
        #1;
        check_all(tag);
        n_txn++;
        $display("txn %0d %s k=%0d en=%0b do_en=%0b data_o=%0d fv=%0d", n_txn, tag, k, en,
                 do_en, data_o, out_filter_v);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        n_txn = 0;
        build_tables();
        model_reset();
        rst = 1'b1;
        filter_v = '0; data_i = '0; di_en = 1'b0; is_first_in = 1'b0; is_last_in = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        @(negedge clk);
        rst = 1'b0;

        step("first", 0, -5, 1'b1, 1'b1, 1'b0);
        step("peak9", mel_edge[10], 1234, 1'b1, 1'b0, 1'b0);
        chk("peak9.slice", CW'(coef[(NF-1-9)*O_BW +: O_BW]), CW'(8191));
        step("e20p1", mel_edge[20] + 1, -777, 1'b1, 1'b0, 1'b0);
        step("k512", 512, 4000, 1'b1, 1'b0, 1'b1);
        chk("k512.zero", coef, '0);
        step("k700", 700, -8192, 1'b1, 1'b1, 1'b1);
        chk("k700.zero", coef, '0);

        step("pulse1", 100, 321, 1'b1, 1'b0, 1'b0);
        step("gap", 200, -99, 1'b0, 1'b1, 1'b1);
        step("pulse2", 300, 55, 1'b1, 1'b0, 1'b0);

        for (int k = 0; k <= 512; k++)
            step("sweep", k, int'($urandom), 1'b1, k == 0, k == 512);

        for (int i = 0; i < 300; i++) begin
            int k;
            k = ($urandom_range(0, 7) == 0) ? int'($urandom_range(513, 1023))
                                           : int'($urandom_range(0, 512));
            step("rand", k, int'($urandom), $urandom_range(0, 3) != 0,
                 $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
        end

        // Asynchronous reset mid-cycle with a valid sample presented.
        filter_v = 10'(mel_edge[30]);
        data_i   = I_BW'(42);
        di_en    = 1'b1;
        #3;
        rst = 1'b1;
        #1;
        model_reset();
        check_all("arst");
        @(posedge clk);
        #1;
        check_all("arst_hold");
        @(negedge clk);
        rst = 1'b0;
        step("post_idle", 40, 17, 1'b0, 1'b0, 1'b0);
        step("post_first", 40, 17, 1'b1, 1'b1, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
